// File: rtl/rom_pkg.sv
// Shared definitions for the program-ROM read-port arbiter: default widths,
// FSM state encoding and transaction owner encoding.
package rom_pkg;

    localparam int ROM_ADDR_W = 16;
    localparam int ROM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACK
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_AUX
    } owner_t;

endpackage

// File: rtl/rom_fetch_arbiter.sv
// Shares one program-ROM read port between instruction fetch (priority) and an
// auxiliary reader; a starvation counter forces aux through after STARVE_LIMIT fetch wins.
module rom_fetch_arbiter
    import rom_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int DATA_W       = ROM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [ADDR_W-1:0] rom_address_nxt;
    logic [DATA_W-1:0] fetch_data_nxt, aux_data_nxt;
    logic              fetch_ack_nxt, aux_ack_nxt;
    logic              aux_wins;

    // Fetch wins contention unless aux has already been passed over LIMIT times.
    assign aux_wins = aux_req && (!fetch_req || (starve_cnt == LIMIT));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nxt       = state;
        owner_nxt       = owner;
        starve_nxt      = starve_cnt;
        rom_address_nxt = rom_address;
        fetch_data_nxt  = fetch_data;
        aux_data_nxt    = aux_data;
        fetch_ack_nxt   = 1'b0;
        aux_ack_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (fetch_req || aux_req) begin
                    state_nxt = READ;
                    if (aux_wins) begin
                        owner_nxt       = OWN_AUX;
                        rom_address_nxt = aux_addr;
                        starve_nxt      = 4'd0;
                    end else begin
                        owner_nxt       = OWN_FETCH;
                        rom_address_nxt = fetch_addr;
                        if (!aux_req)
                            starve_nxt = 4'd0;
                        else if (starve_cnt != LIMIT)
                            starve_nxt = starve_cnt + 4'd1;
                    end
                end
            end
            READ: begin
                state_nxt = ACK;
                if (owner == OWN_AUX)
                    aux_data_nxt = rom_data;
                else
                    fetch_data_nxt = rom_data;
            end
            ACK: begin
                state_nxt     = IDLE;
                fetch_ack_nxt = (owner == OWN_FETCH);
                aux_ack_nxt   = (owner == OWN_AUX);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset aborts any transaction in flight: no ack, returned words cleared.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            owner       <= OWN_FETCH;
            starve_cnt  <= 4'd0;
            rom_address <= '0;
            fetch_data  <= '0;
            aux_data    <= '0;
            fetch_ack   <= 1'b0;
            aux_ack     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            owner       <= owner_nxt;
            starve_cnt  <= starve_nxt;
            rom_address <= rom_address_nxt;
            fetch_data  <= fetch_data_nxt;
            aux_data    <= aux_data_nxt;
            fetch_ack   <= fetch_ack_nxt;
            aux_ack     <= aux_ack_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against a transaction-timeline reference model.
module tb_rom_fetch_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          fetch_req, aux_req;
    logic [AW-1:0] fetch_addr, aux_addr;
    logic          fetch_ack, aux_ack, busy;
    logic [DW-1:0] fetch_data, aux_data, rom_data;
    logic [AW-1:0] rom_address;

    int total = 0;
    int bad   = 0;

    // Reference model: each grant is stamped with its cycle number; capture
    // and ack follow at fixed offsets, and the port is free three edges later.
    int            m_cycle       = 0;
    int            m_grant_cycle = -10;
    bit            m_own_aux;
    int            m_starve;
    logic [AW-1:0] m_rom_address;
    logic [DW-1:0] m_fetch_data, m_aux_data;
    logic          m_fetch_ack, m_aux_ack, m_busy;

    assign rom_data = {16'hA5A5, rom_address};

    always #5 CLK = ~CLK;

    rom_fetch_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_ack    (aux_ack),
        .aux_data   (aux_data),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .busy       (busy)
    );

    task automatic model_step(input logic r, input logic fr, input logic ar,
                              input logic [AW-1:0] fa, input logic [AW-1:0] aa);
        m_cycle++;
        m_fetch_ack = 1'b0;
        m_aux_ack   = 1'b0;
        if (r) begin
            m_rom_address = '0;
            m_fetch_data  = '0;
            m_aux_data    = '0;
            m_starve      = 0;
            m_grant_cycle = m_cycle - 10;
        end else if (m_cycle == m_grant_cycle + 1) begin
            if (m_own_aux) m_aux_data = {16'hA5A5, m_rom_address};
            else           m_fetch_data = {16'hA5A5, m_rom_address};
        end else if (m_cycle == m_grant_cycle + 2) begin
            if (m_own_aux) m_aux_ack = 1'b1;
            else           m_fetch_ack = 1'b1;
        end else if (fr || ar) begin
            m_own_aux     = ar && (!fr || m_starve == LIMIT);
            m_rom_address = m_own_aux ? aa : fa;
            if (!m_own_aux && ar) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            else                  m_starve = 0;
            m_grant_cycle = m_cycle;
        end
        m_busy = (m_cycle - m_grant_cycle) < 2;
    endtask

    // One clock: capture the inputs driven this cycle, step DUT and model, settle at negedge.
    task automatic cyc();
        logic r, fr, ar;
        logic [AW-1:0] fa, aa;
        r = RST; fr = fetch_req; ar = aux_req; fa = fetch_addr; aa = aux_addr;
        @(posedge CLK);
        model_step(r, fr, ar, fa, aa);
        @(negedge CLK);
    endtask

    task automatic wait_ack(input bit want_aux, input int limit, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            cyc();
            n++;
            if (want_aux ? aux_ack : fetch_ack) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; fetch_req = 1'b0; aux_req = 1'b0; fetch_addr = '0; aux_addr = '0;
        cyc(); cyc();
        RST = 1'b0;
        total++; if (rom_address !== '0) begin bad++; $display("FAIL reset_rom_address got %h want 0", rom_address); end
        total++; if (fetch_data !== '0) begin bad++; $display("FAIL reset_fetch_data got %h want 0", fetch_data); end
        total++; if (aux_data !== '0) begin bad++; $display("FAIL reset_aux_data got %h want 0", aux_data); end
        total++; if (fetch_ack !== 1'b0) begin bad++; $display("FAIL reset_fetch_ack got %b want 0", fetch_ack); end
        total++; if (aux_ack !== 1'b0) begin bad++; $display("FAIL reset_aux_ack got %b want 0", aux_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_fetch_only();
        int n; bit seen;
        fetch_addr = 16'h0013; fetch_req = 1'b1;
        wait_ack(1'b0, 10, n, seen);
        fetch_req = 1'b0;
        total++; if (!seen || n != 3) begin bad++; $display("FAIL fetch_latency got %0d seen=%0d want 3", n, seen); end
        total++; if (fetch_data !== 32'hA5A50013) begin bad++; $display("FAIL fetch_data got %h want a5a50013", fetch_data); end
        total++; if (aux_data !== '0) begin bad++; $display("FAIL fetch_only_aux_data got %h want 0", aux_data); end
        cyc();
        total++; if (fetch_ack !== 1'b0) begin bad++; $display("FAIL fetch_ack_width got %b want 0", fetch_ack); end
    endtask

    task automatic test_both_same_cycle();
        int n; bit seen;
        fetch_addr = 16'h0001; aux_addr = 16'h0002;
        fetch_req = 1'b1; aux_req = 1'b1;
        n = 0;
        while (!(fetch_ack || aux_ack) && n < 10) begin cyc(); n++; end
        fetch_req = 1'b0;
        total++; if (fetch_ack !== 1'b1 || aux_ack !== 1'b0 || n != 3) begin
            bad++; $display("FAIL both_first_fetch got fetch_ack=%b aux_ack=%b after %0d want fetch first after 3", fetch_ack, aux_ack, n);
        end
        total++; if (fetch_data !== 32'hA5A50001) begin bad++; $display("FAIL both_fetch_data got %h want a5a50001", fetch_data); end
        wait_ack(1'b1, 10, n, seen);
        aux_req = 1'b0;
        total++; if (!seen || n != 3) begin bad++; $display("FAIL both_aux_latency got %0d seen=%0d want 3", n, seen); end
        total++; if (aux_data !== 32'hA5A50002) begin bad++; $display("FAIL both_aux_data got %h want a5a50002", aux_data); end
        total++; if (fetch_data !== 32'hA5A50001) begin bad++; $display("FAIL both_fetch_hold got %h want a5a50001", fetch_data); end
    endtask

    task automatic test_starvation();
        int n, fetch_acks;
        bit seen;
        fetch_addr = 16'h0040; aux_addr = 16'h0100;
        fetch_req = 1'b1; aux_req = 1'b1;
        n = 0; fetch_acks = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            cyc(); n++;
            if (fetch_ack) begin
                fetch_acks++;
                total++; if (fetch_data !== 32'hA5A50040) begin bad++; $display("FAIL starve_fetch_data got %h want a5a50040", fetch_data); end
            end
            if (aux_ack) seen = 1'b1;
        end
        fetch_req = 1'b0; aux_req = 1'b0;
        total++; if (!seen || fetch_acks != LIMIT) begin bad++; $display("FAIL starve_fetch_count got %0d seen=%0d want %0d", fetch_acks, seen, LIMIT); end
        total++; if (aux_data !== 32'hA5A50100) begin bad++; $display("FAIL starve_aux_data got %h want a5a50100", aux_data); end
        total++; if (dut.starve_cnt !== 4'd0) begin bad++; $display("FAIL starve_cnt_clear got %0d want 0", dut.starve_cnt); end
        cyc(); cyc();
    endtask

    task automatic test_reset_mid_read();
        int n; bit seen;
        aux_addr = 16'h00FF; aux_req = 1'b1;
        cyc();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before got %b want 1", busy); end
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        total++; if (aux_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_abort got aux_ack=%b busy=%b want 0 0", aux_ack, busy); end
        total++; if (aux_data !== '0 || fetch_data !== '0) begin bad++; $display("FAIL rst_data_clear got aux=%h fetch=%h want 0 0", aux_data, fetch_data); end
        wait_ack(1'b1, 10, n, seen);
        aux_req = 1'b0;
        total++; if (!seen || n != 3) begin bad++; $display("FAIL rst_rearb_latency got %0d seen=%0d want 3", n, seen); end
        total++; if (aux_data !== 32'hA5A500FF) begin bad++; $display("FAIL rst_rearb_data got %h want a5a500ff", aux_data); end
    endtask

    task automatic test_aux_pulse();
        int fetch_acks, aux_acks;
        fetch_addr = 16'h0022; fetch_req = 1'b1;
        cyc();
        aux_addr = 16'h0033; aux_req = 1'b1;
        cyc();
        aux_req = 1'b0;
        fetch_acks = 0; aux_acks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (fetch_ack) begin fetch_acks++; fetch_req = 1'b0; end
            if (aux_ack) aux_acks++;
        end
        total++; if (aux_acks != 0) begin bad++; $display("FAIL pulse_no_aux_ack got %0d want 0", aux_acks); end
        total++; if (fetch_acks != 1) begin bad++; $display("FAIL pulse_fetch_acks got %0d want 1", fetch_acks); end
        total++; if (aux_data !== 32'hA5A500FF) begin bad++; $display("FAIL pulse_aux_data got %h want a5a500ff", aux_data); end
        total++; if (fetch_data !== 32'hA5A50022) begin bad++; $display("FAIL pulse_fetch_data got %h want a5a50022", fetch_data); end
    endtask

    task automatic test_random();
        RST = 1'b0;
        for (int i = 0; i < 500; i++) begin
            total++;
            if (fetch_ack !== m_fetch_ack || aux_ack !== m_aux_ack || busy !== m_busy ||
                rom_address !== m_rom_address || fetch_data !== m_fetch_data || aux_data !== m_aux_data) begin
                bad++;
                $display("FAIL random_cycle%0d got ack=%b%b busy=%b addr=%h fd=%h ad=%h want ack=%b%b busy=%b addr=%h fd=%h ad=%h",
                         i, fetch_ack, aux_ack, busy, rom_address, fetch_data, aux_data,
                         m_fetch_ack, m_aux_ack, m_busy, m_rom_address, m_fetch_data, m_aux_data);
            end
            RST = ($urandom_range(99) == 0);
            if (fetch_req && fetch_ack)          fetch_req = ($urandom_range(3) == 0);
            else if (fetch_req)                  fetch_req = ($urandom_range(15) != 0);
            else if ($urandom_range(2) == 0) begin fetch_req = 1'b1; fetch_addr = AW'($urandom); end
            if (aux_req && aux_ack)              aux_req = ($urandom_range(3) == 0);
            else if (aux_req)                    aux_req = ($urandom_range(15) != 0);
            else if ($urandom_range(2) == 0) begin aux_req = 1'b1; aux_addr = AW'($urandom); end
            cyc();
        end
        RST = 1'b0; fetch_req = 1'b0; aux_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_both_same_cycle();
        test_starvation();
        test_reset_mid_read();
        test_aux_pulse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
